// File: rtl/spi_crc_rx_ctrl.sv
// spi_crc_rx_ctrl
// Receive-side sequencer for the SPI slave CRC path. Gathers bytes from the
// SPI shift register into one packet of LEN_DATA payload bits plus an 8-bit
// CRC. It checks the payload with a bit-serial CRC-8, MSB of the payload
// first. It then offers the payload with a pass/fail flag on a valid/ready
// port and keeps a saturating count of CRC failures.
module spi_crc_rx_ctrl #(
   parameter int                LEN_DATA = 24,
   parameter int                LEN_CRC  = 8,
   parameter logic [LEN_CRC-1:0] POLY     = 8'h2F,
   parameter logic [LEN_CRC-1:0] CRC_INIT = 8'h00
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_frame_start,
   input  logic [7:0]          rx_byte,
   input  logic                rx_byte_valid,
   output logic                rx_ready,
   output logic                rx_overrun,
   output logic [LEN_DATA-1:0] pkt_data,
   output logic                pkt_crc_ok,
   output logic [LEN_CRC-1:0]  pkt_crc_calc,
   output logic                pkt_valid,
   input  logic                pkt_ready,
   output logic [7:0]          crc_err_cnt
);

   localparam int NBYTES = LEN_DATA / 8;
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int BIT_W  = $clog2(LEN_DATA);

   // Index of the CRC byte inside a packet; payload bytes come before it.
   localparam logic [CNT_W-1:0] CRC_BYTE = CNT_W'(NBYTES);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(LEN_DATA - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CALC    = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   // One serial CRC step: shift left, fold in the polynomial on feedback.
   function automatic logic [LEN_CRC-1:0] crc_step(
      input logic [LEN_CRC-1:0] crc,
      input logic               d
   );
      logic fb;
      fb       = crc[LEN_CRC-1] ^ d;
      crc_step = {crc[LEN_CRC-2:0], 1'b0} ^ (fb ? POLY : {LEN_CRC{1'b0}});
   endfunction

   state_t              state_r;
   state_t              state_next_s;

   logic [CNT_W-1:0]    byte_cnt_r;
   logic [BIT_W-1:0]    bit_idx_r;
   logic [LEN_DATA-1:0] data_r;
   logic [LEN_CRC-1:0]  crc_rx_r;
   logic [LEN_CRC-1:0]  crc_r;

   logic                rx_ready_r;
   logic                rx_overrun_r;
   logic [LEN_DATA-1:0] pkt_data_r;
   logic                pkt_crc_ok_r;
   logic [LEN_CRC-1:0]  pkt_crc_calc_r;
   logic                pkt_valid_r;
   logic [7:0]          crc_err_cnt_r;

   logic                accept_s;
   logic                overrun_s;
   logic                calc_last_s;
   logic                handshake_s;
   logic                resync_s;
   logic [CNT_W-1:0]    eff_cnt_s;
   logic [LEN_CRC-1:0]  crc_next_s;
   logic                ready_next_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = ST_COLLECT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (accept_s && (eff_cnt_s == CRC_BYTE)) begin
               state_next_s = ST_CALC;
            end else if (accept_s) begin
               state_next_s = ST_COLLECT;
            end else if (rx_frame_start) begin
               // A bare frame start throws the partial packet away.
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_COLLECT;
            end
         end
         ST_CALC: begin
            if (calc_last_s) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_CALC;
            end
         end
         ST_HOLD: begin
            if (handshake_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Output / control decode from the current state.
   always_comb begin
      accept_s     = 1'b0;
      overrun_s    = 1'b0;
      calc_last_s  = 1'b0;
      handshake_s  = 1'b0;
      resync_s     = 1'b0;
      ready_next_s = 1'b0;
      crc_next_s   = crc_step(crc_r, data_r[bit_idx_r]);
      case (state_r)
         ST_IDLE, ST_COLLECT: begin
            accept_s = rx_byte_valid;
            // The frame start takes effect first, so a byte that arrives
            // with it becomes byte 0.
            resync_s = rx_frame_start | (state_r == ST_IDLE);
         end
         ST_CALC: begin
            overrun_s   = rx_byte_valid;
            calc_last_s = (bit_idx_r == {BIT_W{1'b0}});
         end
         ST_HOLD: begin
            overrun_s   = rx_byte_valid;
            handshake_s = pkt_valid_r & pkt_ready;
         end
         default: begin
            accept_s = 1'b0;
         end
      endcase
      if (resync_s) begin
         eff_cnt_s = {CNT_W{1'b0}};
      end else begin
         eff_cnt_s = byte_cnt_r;
      end
      if ((state_next_s == ST_IDLE) || (state_next_s == ST_COLLECT)) begin
         ready_next_s = 1'b1;
      end else begin
         ready_next_s = 1'b0;
      end
   end

   // Datapath: byte assembly, serial CRC, result latch and error count.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_r     <= {CNT_W{1'b0}};
         bit_idx_r      <= {BIT_W{1'b0}};
         data_r         <= {LEN_DATA{1'b0}};
         crc_rx_r       <= {LEN_CRC{1'b0}};
         crc_r          <= CRC_INIT;
         rx_ready_r     <= 1'b1;
         rx_overrun_r   <= 1'b0;
         pkt_data_r     <= {LEN_DATA{1'b0}};
         pkt_crc_ok_r   <= 1'b0;
         pkt_crc_calc_r <= {LEN_CRC{1'b0}};
         pkt_valid_r    <= 1'b0;
         crc_err_cnt_r  <= 8'h00;
      end else begin
         rx_ready_r   <= ready_next_s;
         rx_overrun_r <= overrun_s;
         case (state_r)
            ST_IDLE, ST_COLLECT: begin
               if (accept_s) begin
                  for (int i = 0; i < NBYTES; i++) begin
                     if (eff_cnt_s == CNT_W'(i)) begin
                        data_r[LEN_DATA-1-8*i -: 8] <= rx_byte;
                     end
                  end
                  if (eff_cnt_s == CRC_BYTE) begin
                     crc_rx_r  <= rx_byte;
                     bit_idx_r <= BIT_TOP;
                     crc_r     <= CRC_INIT;
                  end
                  byte_cnt_r <= eff_cnt_s + CNT_W'(1);
               end else if (resync_s) begin
                  byte_cnt_r <= {CNT_W{1'b0}};
               end
            end
            ST_CALC: begin
               crc_r     <= crc_next_s;
               bit_idx_r <= bit_idx_r - BIT_W'(1);
               if (calc_last_s) begin
                  pkt_data_r     <= data_r;
                  pkt_crc_calc_r <= crc_next_s;
                  pkt_crc_ok_r   <= (crc_next_s == crc_rx_r);
                  pkt_valid_r    <= 1'b1;
                  if ((crc_next_s != crc_rx_r) && (crc_err_cnt_r != 8'hFF)) begin
                     crc_err_cnt_r <= crc_err_cnt_r + 8'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (handshake_s) begin
                  pkt_valid_r <= 1'b0;
                  byte_cnt_r  <= {CNT_W{1'b0}};
               end
            end
            default: begin
               byte_cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign rx_ready     = rx_ready_r;
   assign rx_overrun   = rx_overrun_r;
   assign pkt_data     = pkt_data_r;
   assign pkt_crc_ok   = pkt_crc_ok_r;
   assign pkt_crc_calc = pkt_crc_calc_r;
   assign pkt_valid    = pkt_valid_r;
   assign crc_err_cnt  = crc_err_cnt_r;

endmodule
